// File: rtl/updown_pkg.sv
// Shared encodings and bound helper for the up/down auto-repeat counter.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_RPT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  function automatic logic [31:0] clamp_u32(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/updown_repeat_timer.sv
// Loadable down-counter that times the hold delay and repeat period.
module repeat_timer #(
  parameter int TMR_W = 25
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] tmr;

  always_ff @(posedge CLK) begin
    if (Rst) begin
      tmr <= '0;
    end else if (load) begin
      tmr <= load_val;
    end else if (dec && (tmr != '0)) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  assign zero = (tmr == '0);

endmodule

// File: rtl/updown_repeat_counter.sv
// Bounded up/down counter with hold-to-repeat stepping, load, bound flags and event pulses.
module updown_repeat_counter
  import updown_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 255,
  parameter int RST_VAL       = 128,
  parameter int STEP          = 1,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int TMR_W         = 25
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             Sm,
  input  logic             Rs,
  input  logic             Ld,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] count,
  output logic             at_min,
  output logic             at_max,
  output logic             step_pulse,
  output logic             limit_pulse
);

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   MIN_E  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_E  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_E = (WIDTH+1)'(STEP);
  localparam logic [TMR_W-1:0] DLY_LD = TMR_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TMR_W-1:0] PER_LD = TMR_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  // Returns {limit_hit, next_value}; the extra bit keeps count+STEP from overflowing.
  function automatic logic [WIDTH:0] step_val(input logic [WIDTH-1:0] cur, input dir_t d);
    logic [WIDTH:0] ext;
    logic [WIDTH:0] res;
    logic           lim;
    ext = {1'b0, cur};
    lim = 1'b0;
    if (d == DOWN) begin
      if (ext < MIN_E + STEP_E) begin
        lim = 1'b1;
        res = (WRAP != 0) ? MAX_E : MIN_E;
      end else begin
        res = ext - STEP_E;
      end
    end else begin
      if (ext + STEP_E > MAX_E) begin
        lim = 1'b1;
        res = (WRAP != 0) ? MIN_E : MAX_E;
      end else begin
        res = ext + STEP_E;
      end
    end
    return {lim, res[WIDTH-1:0]};
  endfunction

  state_t           state, state_n;
  dir_t             dir, dir_n, req;
  logic             step_ev;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic [WIDTH:0]   stp;
  logic [WIDTH-1:0] count_n;
  logic             step_n, limit_n;

  assign req = Rs ? DOWN : (Sm ? UP : NONE);

  repeat_timer #(.TMR_W(TMR_W)) u_tmr (
    .CLK      (CLK),
    .Rst      (Rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    step_ev  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = DLY_LD;
    tmr_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (req != NONE) begin
          step_ev  = 1'b1;
          dir_n    = req;
          tmr_load = 1'b1;
          state_n  = HOLD_DLY;
        end
      end
      default: begin
        if (req == NONE) begin
          state_n = IDLE;
          dir_n   = NONE;
        end else if (req != dir) begin
          step_ev  = 1'b1;
          dir_n    = req;
          tmr_load = 1'b1;
          state_n  = HOLD_DLY;
        end else if (REPEAT_DELAY == 0) begin
          // Repeat disabled: park here with the timer frozen until release.
          state_n = HOLD_DLY;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          step_ev  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = PER_LD;
          state_n  = HOLD_RPT;
        end
      end
    endcase
  end

  // Load overrides any due step; the FSM keeps running so a held button is not re-stepped.
  always_comb begin
    stp     = step_val(count, req);
    count_n = count;
    step_n  = 1'b0;
    limit_n = 1'b0;
    if (Ld) begin
      count_n = WIDTH'(clamp_u32(32'(Din), 32'(MIN_VAL), 32'(MAX_VAL)));
    end else if (step_ev) begin
      count_n = stp[WIDTH-1:0];
      step_n  = 1'b1;
      limit_n = stp[WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state       <= IDLE;
      dir         <= NONE;
      count       <= RST_W;
      at_min      <= (RST_W == MIN_W);
      at_max      <= (RST_W == MAX_W);
      step_pulse  <= 1'b0;
      limit_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      dir         <= dir_n;
      count       <= count_n;
      at_min      <= (count_n == MIN_W);
      at_max      <= (count_n == MAX_W);
      step_pulse  <= step_n;
      limit_pulse <= limit_n;
    end
  end

endmodule

// File: tb/tb_updown_repeat_counter.sv
// Directed bench: saturating and wrapping instances share stimulus; expectations are hand-derived.
module tb_updown_repeat_counter;

  logic       CLK = 1'b0;
  logic       Rst = 1'b1;
  logic       Sm = 1'b0, Rs = 1'b0, Ld = 1'b0;
  logic [7:0] Din = 8'd0;

  logic [7:0] count, count_w;
  logic       at_min, at_max, step_pulse, limit_pulse;
  logic       at_min_w, at_max_w, step_pulse_w, limit_pulse_w;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  updown_repeat_counter #(
    .WIDTH(8), .MIN_VAL(10), .MAX_VAL(20), .RST_VAL(15), .STEP(2), .WRAP(0),
    .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .TMR_W(4)
  ) dut (
    .CLK(CLK), .Rst(Rst), .Sm(Sm), .Rs(Rs), .Ld(Ld), .Din(Din),
    .count(count), .at_min(at_min), .at_max(at_max),
    .step_pulse(step_pulse), .limit_pulse(limit_pulse)
  );

  updown_repeat_counter #(
    .WIDTH(8), .MIN_VAL(10), .MAX_VAL(20), .RST_VAL(15), .STEP(2), .WRAP(1),
    .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .TMR_W(4)
  ) dutw (
    .CLK(CLK), .Rst(Rst), .Sm(Sm), .Rs(Rs), .Ld(Ld), .Din(Din),
    .count(count_w), .at_min(at_min_w), .at_max(at_max_w),
    .step_pulse(step_pulse_w), .limit_pulse(limit_pulse_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Sm = 0; Rs = 0; Ld = 0;
    Rst = 1;
    tick();
    Rst = 0;
  endtask

  // Test 3 expectations per edge 0..10
  int exp3_cnt [11] = '{17, 17, 17, 17, 19, 19, 20, 20, 20, 20, 20};
  int exp3_stp [11] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1};
  int exp3_lim [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
  int exp3_max [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    // 1. Reset
    Rst = 1;
    tick();
    tick();
    chk("rst_count", count, 15);
    chk("rst_at_min", at_min, 0);
    chk("rst_at_max", at_max, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_limit", limit_pulse, 0);
    Rst = 0;
    Sm = 1;
    tick();
    chk("t1_first_step", count, 17);
    tick();
    Rst = 1;
    tick();
    chk("t1_midhold_rst", count, 15);
    Rst = 0;
    tick();
    chk("t1_after_rst_step", count, 17);
    chk("t1_after_rst_pulse", step_pulse, 1);
    Sm = 0;
    tick();

    // 2. Single press
    do_reset();
    Sm = 1;
    tick();
    chk("t2_count", count, 17);
    chk("t2_pulse_hi", step_pulse, 1);
    Sm = 0;
    tick();
    chk("t2_pulse_lo", step_pulse, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_idle_count", count, 17);
      chk("t2_idle_pulse", step_pulse, 0);
    end

    // 3. Hold with saturation
    do_reset();
    Sm = 1;
    for (int e = 0; e < 11; e++) begin
      tick();
      chk($sformatf("t3_count_e%0d", e), count, exp3_cnt[e]);
      chk($sformatf("t3_step_e%0d", e), step_pulse, exp3_stp[e]);
      chk($sformatf("t3_limit_e%0d", e), limit_pulse, exp3_lim[e]);
      chk($sformatf("t3_atmax_e%0d", e), at_max, exp3_max[e]);
    end
    Sm = 0;
    tick();

    // 4. Wrap instance
    Ld = 1; Din = 8'd11;
    tick();
    chk("t4_load", count_w, 11);
    Ld = 0; Rs = 1;
    tick();
    chk("t4_wrap_dn_count", count_w, 20);
    chk("t4_wrap_dn_limit", limit_pulse_w, 1);
    chk("t4_wrap_dn_atmax", at_max_w, 1);
    Rs = 0;
    tick();
    chk("t4_idle_limit", limit_pulse_w, 0);
    Sm = 1;
    tick();
    chk("t4_wrap_up_count", count_w, 10);
    chk("t4_wrap_up_limit", limit_pulse_w, 1);
    chk("t4_wrap_up_atmin", at_min_w, 1);
    Sm = 0;
    tick();

    // 5. Rs priority and direction change
    do_reset();
    Sm = 1; Rs = 1;
    tick();
    chk("t5_e0_rs_wins", count, 13);
    tick();
    chk("t5_e1", count, 13);
    Rs = 0;
    tick();
    chk("t5_e2_dirchg", count, 15);
    chk("t5_e2_pulse", step_pulse, 1);
    for (int e = 3; e < 6; e++) begin
      tick();
      chk($sformatf("t5_e%0d_hold", e), count, 15);
    end
    tick();
    chk("t5_e6_repeat", count, 17);
    chk("t5_e6_pulse", step_pulse, 1);
    Sm = 0;
    tick();

    // 6. Load during hold
    do_reset();
    Sm = 1;
    tick();
    chk("t6_e0", count, 17);
    tick();
    Ld = 1; Din = 8'd200;
    tick();
    chk("t6_e2_clamp", count, 20);
    chk("t6_e2_no_step", step_pulse, 0);
    chk("t6_e2_no_limit", limit_pulse, 0);
    chk("t6_e2_atmax", at_max, 1);
    Ld = 0;
    tick();
    chk("t6_e3_no_step", step_pulse, 0);
    tick();
    chk("t6_e4_count", count, 20);
    chk("t6_e4_step", step_pulse, 1);
    chk("t6_e4_limit", limit_pulse, 1);
    Sm = 0;
    tick();
    Ld = 1; Din = 8'd3;
    tick();
    Ld = 0;
    chk("t6_low_clamp", count, 10);
    chk("t6_low_atmin", at_min, 1);
    chk("t6_low_atmax", at_max, 0);
    chk("t6_low_no_step", step_pulse, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_repeat_counter.md
Name: updown_repeat_counter

Overview:
- Parametrised up/down counter for game-state values such as ship X position, menu index and lives.
- Sm steps up and Rs steps down. Bounds are programmable, with saturate or wrap behaviour.
- Holding a button auto-repeats after a hold delay, so raw debounced button/mouse levels can drive it directly.
- Adds synchronous load, bound flags and event pulses for the sprite/score logic downstream.

Parameters:
- WIDTH, 8: counter width in bits.
- MIN_VAL, 0: lower bound, inclusive.
- MAX_VAL, 255: upper bound, inclusive. Requires MIN_VAL <= MAX_VAL < 2**WIDTH.
- RST_VAL, 128: value on reset. Must lie in [MIN_VAL, MAX_VAL].
- STEP, 1: increment/decrement per step event. Requires 1 <= STEP <= MAX_VAL-MIN_VAL.
- WRAP, 0: 0 = saturate at bounds; 1 = wrap to the opposite bound.
- REPEAT_DELAY, 25000000: cycles from first step to first repeat step. 0 disables repeat (one step per press).
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat steps. Must be >= 1.
- TMR_W, 25: timer width. Must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLK, input, 1: system clock.
- Rst, input, 1: synchronous, active-high reset.
- Sm, input, 1: step-up request (level).
- Rs, input, 1: step-down request (level). Has priority over Sm.
- Ld, input, 1: synchronous load of Din.
- Din, input, WIDTH: load value. Clamped into bounds.
- count, output, WIDTH: current value (registered).
- at_min, output, 1: registered; 1 when count == MIN_VAL.
- at_max, output, 1: registered; 1 when count == MAX_VAL.
- step_pulse, output, 1: one-cycle pulse on every step event.
- limit_pulse, output, 1: one-cycle pulse on a step event that clamped or wrapped.

Behaviour:
- Reset values: count = RST_VAL; at_min/at_max reflect RST_VAL; step_pulse = 0; limit_pulse = 0; FSM = IDLE; timer = 0; dir = NONE.
- Rst has absolute priority, including mid-hold.
- Requested direction each cycle: Rs ? DOWN : Sm ? UP : NONE.
- FSM states: IDLE, HOLD_DLY, HOLD_RPT.
- IDLE:
  - req != NONE: step event this edge; latch dir = req; timer = REPEAT_DELAY-1; go to HOLD_DLY.
  - If REPEAT_DELAY == 0, go to HOLD_RPT-free wait: stay in HOLD_DLY with the timer frozen until release.
- HOLD_DLY / HOLD_RPT:
  - req == NONE: go to IDLE, no step.
  - req != dir (direction change): step immediately in the new direction; dir = req; timer = REPEAT_DELAY-1; go to HOLD_DLY.
  - timer != 0: timer decrements.
  - timer == 0 (repeat enabled): step event; timer = REPEAT_PERIOD-1; go to HOLD_RPT.
- Resulting spacing: first step at the press edge, second REPEAT_DELAY cycles later, then every REPEAT_PERIOD cycles.
- Step arithmetic is done in WIDTH+1 bits to avoid overflow.
  - UP: if count+STEP > MAX_VAL, result is MAX_VAL (WRAP=0) or MIN_VAL (WRAP=1), and limit_pulse=1.
  - DOWN: if count < MIN_VAL+STEP, result is MIN_VAL (WRAP=0) or MAX_VAL (WRAP=1), and limit_pulse=1.
- A step at a bound in saturate mode still asserts step_pulse and limit_pulse; count is unchanged.
- Ld (below Rst, above steps):
  - count = clamp(Din, MIN_VAL, MAX_VAL).
  - Any step due this cycle is suppressed; no pulses are issued.
  - FSM and timer continue unaffected, so a held button is not re-stepped by the load.
- at_min, at_max, step_pulse and limit_pulse are registered with count, so they are valid in the same cycle count changes.
- Latency: input sampled at edge N; count, flags and pulses are visible after edge N.

Decomposition:
- Package updown_pkg:
  - FSM state encoding: IDLE=2'd0, HOLD_DLY=2'd1, HOLD_RPT=2'd2.
  - Direction encoding: NONE=2'd0, UP=2'd1, DOWN=2'd2.
  - Clamp/step helper function.
- One sub-module, repeat_timer: loadable down-counter.
  - Ports: CLK, Rst, load, load_val, dec, zero.
  - Instanced once.
- The FSM and arithmetic stay in the top level.

Test Plan (WIDTH=8, MIN_VAL=10, MAX_VAL=20, RST_VAL=15, STEP=2, REPEAT_DELAY=4, REPEAT_PERIOD=2 unless noted):
1. Reset: assert Rst 2 cycles -> count=15, at_min=0, at_max=0, pulses 0. Assert Rst while Sm is held -> count returns to 15, FSM returns to IDLE, and the next held cycle steps to 17.
2. Single press: Sm high 1 cycle -> count=17 after that edge; step_pulse high exactly 1 cycle; no further change over 20 idle cycles.
3. Hold Sm 11 cycles (edges 0..10), WRAP=0 -> steps at edges 0, 4, 6, 8, 10 give count 17, 19, 20, 20, 20. limit_pulse at edges 6, 8, 10; at_max=1 from edge 6.
4. WRAP=1, load Din=11, then pulse Rs -> count=20, limit_pulse=1, at_max=1. Pulse Sm -> count=10, limit_pulse=1, at_min=1.
5. Hold Sm and Rs together from 15 -> count 13 at edge 0 (Rs wins). Drop Rs at edge 2 with Sm still held -> count 15 at edge 2 (immediate direction-change step); next step at edge 6.
6. Hold Sm; assert Ld with Din=200 at edge 2 -> count=20 (clamped), no pulses that edge. Repeat schedule unchanged: step at edge 4 with limit_pulse=1. Separately, Ld with Din=3 -> count=10, at_min=1.
